// File: rtl/charge_session_ctrl_pkg.sv
// Shared state encoding and default sizing for the charger session controller.
package charge_session_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_CHARGING = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int unsigned TICKS_PER_SEC_DEF = 1000;
    localparam int unsigned CREDIT_W_DEF      = 14;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/charge_session_ctrl_tick_divider.sv
// Prescaler producing a one-cycle sec_tick every TICKS_PER_SEC enabled cycles.
module tick_divider
    import charge_session_ctrl_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic sec_tick
);

    localparam int unsigned      CNT_W    = cnt_width(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count enabled cycles, wrapping at TICKS_PER_SEC; clear wins over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Tick is decoded from the count so the FSM can act on the wrap edge itself.
    assign sec_tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/charge_session_ctrl.sv
// Coin-operated charger session FSM: credit accumulation, arming, charge countdown, done hold.
module charge_session_ctrl
    import charge_session_ctrl_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF,
    parameter int unsigned SEC_PER_COIN  = 60,
    parameter int unsigned MAX_CREDIT    = 9999,
    parameter int unsigned WAIT_TIMEOUT  = 10,
    parameter int unsigned DONE_HOLD     = 3,
    parameter int unsigned CREDIT_W      = CREDIT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin,
    input  logic                start_btn,
    input  logic                cancel_btn,
    output logic                charging,
    output logic [CREDIT_W-1:0] credit_sec,
    output logic [1:0]          state,
    output logic                coin_reject,
    output logic                done_pulse
);

    localparam int unsigned SUM_W   = CREDIT_W + 1;
    localparam int unsigned SEC_MAX = (WAIT_TIMEOUT > DONE_HOLD) ? WAIT_TIMEOUT : DONE_HOLD;
    localparam int unsigned SEC_W   = cnt_width(SEC_MAX + 1);

    state_t              state_q, state_nx;
    logic [CREDIT_W-1:0] credit_q, credit_nx, credit_base;
    logic [SEC_W-1:0]    sec_q, sec_nx, sec_inc;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_fits, coin_live, coin_ok, cancel_live;
    logic                reject_nx;
    logic                sec_tick, presc_clear, presc_en;

    // Prescaler runs outside IDLE and restarts on every state change.
    assign presc_en    = (state_q != ST_IDLE);
    assign presc_clear = (state_nx != state_q) || (state_q == ST_IDLE);

    tick_divider #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_divider (
        .clk     (clk),
        .reset   (reset),
        .clear   (presc_clear),
        .enable  (presc_en),
        .sec_tick(sec_tick)
    );

    // Fold the charge-tick decrement in first so a coin on a tick lands on credit-1.
    always_comb begin
        credit_base = credit_q;
        if ((state_q == ST_CHARGING) && sec_tick && (credit_q != '0)) begin
            credit_base = credit_q - CREDIT_W'(1);
        end
    end

    // Coin add is one bit wider than credit so the ceiling check cannot wrap.
    assign coin_sum    = {1'b0, credit_base} + SUM_W'(SEC_PER_COIN);
    assign coin_fits   = (coin_sum <= SUM_W'(MAX_CREDIT));
    assign cancel_live = cancel_btn && ((state_q == ST_ARMED) || (state_q == ST_CHARGING));
    assign coin_live   = coin && !cancel_live;
    assign coin_ok     = coin_live && coin_fits;
    assign sec_inc     = sec_q + SEC_W'(1);

    // Next-state, credit and second-counter logic; priority cancel > coin > start.
    always_comb begin
        state_nx  = state_q;
        credit_nx = credit_q;
        sec_nx    = sec_q;
        reject_nx = coin_live && !coin_fits;

        case (state_q)
            ST_IDLE: begin
                if (coin_ok) begin
                    state_nx  = ST_ARMED;
                    credit_nx = coin_sum[CREDIT_W-1:0];
                end
            end
            ST_ARMED: begin
                if (cancel_live) begin
                    state_nx  = ST_IDLE;
                    credit_nx = '0;
                end else if (coin_ok) begin
                    credit_nx = coin_sum[CREDIT_W-1:0];
                    sec_nx    = '0;
                end else if (start_btn && !coin) begin
                    state_nx = ST_CHARGING;
                end else if (sec_tick) begin
                    if (sec_inc == SEC_W'(WAIT_TIMEOUT)) begin
                        state_nx  = ST_IDLE;
                        credit_nx = '0;
                    end else begin
                        sec_nx = sec_inc;
                    end
                end
            end
            ST_CHARGING: begin
                if (cancel_live) begin
                    state_nx  = ST_DONE;
                    credit_nx = '0;
                end else if (coin_ok) begin
                    credit_nx = coin_sum[CREDIT_W-1:0];
                end else if (sec_tick) begin
                    credit_nx = credit_base;
                    if (credit_base == '0) begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (coin_ok) begin
                    state_nx  = ST_ARMED;
                    credit_nx = coin_sum[CREDIT_W-1:0];
                end else if (sec_tick) begin
                    if (sec_inc == SEC_W'(DONE_HOLD)) begin
                        state_nx  = ST_IDLE;
                        credit_nx = '0;
                    end else begin
                        sec_nx = sec_inc;
                    end
                end
            end
            default: begin
                state_nx  = ST_IDLE;
                credit_nx = '0;
            end
        endcase

        if (state_nx != state_q) begin
            sec_nx = '0;
        end
    end

    // State, credit, second counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            credit_q    <= '0;
            sec_q       <= '0;
            charging    <= 1'b0;
            coin_reject <= 1'b0;
            done_pulse  <= 1'b0;
        end else begin
            state_q     <= state_nx;
            credit_q    <= credit_nx;
            sec_q       <= sec_nx;
            charging    <= (state_nx == ST_CHARGING);
            coin_reject <= reject_nx;
            done_pulse  <= (state_nx == ST_DONE) && (state_q != ST_DONE);
        end
    end

    assign state      = state_q;
    assign credit_sec = credit_q;

endmodule
